// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl: display timing and pattern-select controller for the VGA
// test-pattern generator. Generates pixel coordinates, syncs and blanking for
// one display mode. Pattern changes, manual or automatic, are committed only at
// the last pixel of a frame so that no frame ever shows two patterns.

module vga_pattern_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FRAMES_PER_MODE = 60
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        iAuto_EN,
  input  logic        iMode_Req,
  input  logic        iMode_Val,
  output logic        oMode_Ack,
  output logic [10:0] oVGA_X,
  output logic [10:0] oVGA_Y,
  output logic        oColor_SW,
  output logic        oHS,
  output logic        oVS,
  output logic        oBLANK_n,
  output logic        oFrame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  // frame counter only needs to reach FRAMES_PER_MODE-1; keep at least one bit
  localparam int FC_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_MODE - 1);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } modeState_t;

  // raster counters
  logic [10:0] hCnt_q, hCnt_d;
  logic [10:0] vCnt_q, vCnt_d;
  logic        hEnd;
  logic        vEnd;
  logic        frameBnd;

  // raw timing decoded from the counters
  logic        visible;
  logic        hsRaw;
  logic        vsRaw;

  // coordinate / frame-start stage (1 cycle after counters)
  logic [10:0] vgaX_q;
  logic [10:0] vgaY_q;
  logic        frameStart_q;

  // sync/blank pipeline (2 cycles after counters)
  logic        hs1_q, hs2_q;
  logic        vs1_q, vs2_q;
  logic        blank1_q, blank2_q;

  // mode control
  modeState_t     state_q, state_d;
  logic           pendVal_q, pendVal_d;
  logic [FC_W-1:0] frameCnt_q, frameCnt_d;
  logic           colorSel_q, colorSel_d;
  logic           ackPulse_q, ackPulse_d;
  logic           colorOut_q;
  logic           ackOut_q;

  assign hEnd     = (hCnt_q == H_LAST);
  assign vEnd     = (vCnt_q == V_LAST);
  assign frameBnd = hEnd && vEnd;

  assign visible = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
  assign hsRaw   = !((hCnt_q >= HS_START) && (hCnt_q < HS_END));
  assign vsRaw   = !((vCnt_q >= VS_START) && (vCnt_q < VS_END));

  // next raster position: h wraps every line, v advances on each h wrap
  always_comb begin
    hCnt_d = hCnt_q + 11'd1;
    vCnt_d = vCnt_q;
    if (hEnd) begin
      hCnt_d = '0;
      if (vEnd) begin
        vCnt_d = '0;
      end else begin
        vCnt_d = vCnt_q + 11'd1;
      end
    end
  end

  // raster counter registers
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else begin
      hCnt_q <= hCnt_d;
      vCnt_q <= vCnt_d;
    end
  end

  // coordinates are zeroed outside the visible area; frame start marks (0,0)
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vgaX_q       <= '0;
      vgaY_q       <= '0;
      frameStart_q <= 1'b0;
    end else begin
      vgaX_q       <= visible ? hCnt_q : 11'd0;
      vgaY_q       <= visible ? vCnt_q : 11'd0;
      frameStart_q <= (hCnt_q == 11'd0) && (vCnt_q == 11'd0);
    end
  end

  // two-stage delay so syncs and blank line up with the generator's colour register
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs1_q    <= 1'b1;
      hs2_q    <= 1'b1;
      vs1_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank1_q <= 1'b0;
      blank2_q <= 1'b0;
    end else begin
      hs1_q    <= hsRaw;
      hs2_q    <= hs1_q;
      vs1_q    <= vsRaw;
      vs2_q    <= vs1_q;
      blank1_q <= visible;
      blank2_q <= blank1_q;
    end
  end

  // mode decisions: manual requests wait for the frame boundary and beat any auto toggle
  always_comb begin
    state_d    = state_q;
    pendVal_d  = pendVal_q;
    frameCnt_d = frameCnt_q;
    colorSel_d = colorSel_q;
    ackPulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frameBnd) begin
          if (iMode_Req) begin
            colorSel_d = iMode_Val;
            ackPulse_d = 1'b1;
            frameCnt_d = '0;
          end else if (iAuto_EN) begin
            if (frameCnt_q == FC_LAST) begin
              colorSel_d = ~colorSel_q;
              frameCnt_d = '0;
            end else begin
              frameCnt_d = frameCnt_q + FC_ONE;
            end
          end
        end else if (iMode_Req) begin
          pendVal_d = iMode_Val;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (frameBnd) begin
          colorSel_d = iMode_Req ? iMode_Val : pendVal_q;
          ackPulse_d = 1'b1;
          frameCnt_d = '0;
          state_d    = IDLE;
        end else if (iMode_Req) begin
          pendVal_d = iMode_Val;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // mode state registers, updated at the frame boundary decision
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q    <= IDLE;
      pendVal_q  <= 1'b0;
      frameCnt_q <= '0;
      colorSel_q <= 1'b1;
      ackPulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pendVal_q  <= pendVal_d;
      frameCnt_q <= frameCnt_d;
      colorSel_q <= colorSel_d;
      ackPulse_q <= ackPulse_d;
    end
  end

  // extra stage so the new pattern and its ack appear with the next frame start
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      colorOut_q <= 1'b1;
      ackOut_q   <= 1'b0;
    end else begin
      colorOut_q <= colorSel_q;
      ackOut_q   <= ackPulse_q;
    end
  end

  assign oVGA_X       = vgaX_q;
  assign oVGA_Y       = vgaY_q;
  assign oFrame_Start = frameStart_q;
  assign oHS          = hs2_q;
  assign oVS          = vs2_q;
  assign oBLANK_n     = blank2_q;
  assign oColor_SW    = colorOut_q;
  assign oMode_Ack    = ackOut_q;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// tb_vga_pattern_ctrl: directed stimulus frame by frame; each frame pushes the
// expected state of the next frame start into a queue, and an independent
// monitor pops and compares whenever the DUT raises oFrame_Start.

module tb_vga_pattern_ctrl;

  localparam int FRAME_LEN = 98;

  logic        clk     = 1'b0;
  logic        rstN    = 1'b1;
  logic        autoEn  = 1'b0;
  logic        modeReq = 1'b0;
  logic        modeVal = 1'b0;
  logic        oMode_Ack;
  logic [10:0] oVGA_X;
  logic [10:0] oVGA_Y;
  logic        oColor_SW;
  logic        oHS;
  logic        oVS;
  logic        oBLANK_n;
  logic        oFrame_Start;

  typedef struct {
    int gap;
    int color;
    int ack;
  } frameExp_t;

  frameExp_t expQ[$];
  frameExp_t expItem;

  int totalChecks = 0;
  int passChecks  = 0;

  int offset     = 0;
  bit haveFrame  = 1'b0;
  int lastColor  = 1;
  int hsLow, hsFirst, vsLow, vsFirst, blankCnt, blankFirst;
  int x19, y19, x49, y49, x50, y50;

  vga_pattern_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FRAMES_PER_MODE(3)
  ) dut (
    .iVGA_CLK    (clk),
    .iRST_n      (rstN),
    .iAuto_EN    (autoEn),
    .iMode_Req   (modeReq),
    .iMode_Val   (modeVal),
    .oMode_Ack   (oMode_Ack),
    .oVGA_X      (oVGA_X),
    .oVGA_Y      (oVGA_Y),
    .oColor_SW   (oColor_SW),
    .oHS         (oHS),
    .oVS         (oVS),
    .oBLANK_n    (oBLANK_n),
    .oFrame_Start(oFrame_Start)
  );

  // free-running pixel clock
  always #5 clk = ~clk;

  function automatic void checkOutput(string name, int actual, int expected);
    totalChecks++;
    if (actual == expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endfunction

  function automatic void clearStats();
    hsLow = 0; hsFirst = -1; vsLow = 0; vsFirst = -1; blankCnt = 0; blankFirst = -1;
    x19 = -1; y19 = -1; x49 = -1; y49 = -1; x50 = -1; y50 = -1;
  endfunction

  function automatic void accumulate(int o);
    if (!oHS) begin
      hsLow++;
      if (hsFirst < 0) hsFirst = o;
    end
    if (!oVS) begin
      vsLow++;
      if (vsFirst < 0) vsFirst = o;
    end
    if (oBLANK_n) begin
      blankCnt++;
      if (blankFirst < 0) blankFirst = o;
    end
    if (o == 19) begin x19 = int'(oVGA_X); y19 = int'(oVGA_Y); end
    if (o == 49) begin x49 = int'(oVGA_X); y49 = int'(oVGA_Y); end
    if (o == 50) begin x50 = int'(oVGA_X); y50 = int'(oVGA_Y); end
  endfunction

  // monitor: samples 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (!rstN) begin
      offset    = 0;
      haveFrame = 1'b0;
      lastColor = 1;
    end else begin
      offset++;
      if (oFrame_Start) begin
        if (haveFrame) begin
          checkOutput("hsLowCycles", hsLow, 14);
          checkOutput("hsFirstOffset", hsFirst, 11);
          checkOutput("vsLowCycles", vsLow, 14);
          checkOutput("vsFirstOffset", vsFirst, 71);
          checkOutput("blankHighCycles", blankCnt, 32);
          checkOutput("blankFirstOffset", blankFirst, 1);
          checkOutput("x@19", x19, 5);
          checkOutput("y@19", y19, 1);
          checkOutput("x@49", x49, 7);
          checkOutput("y@49", y49, 3);
          checkOutput("x@50", x50, 0);
          checkOutput("y@50", y50, 0);
        end
        if (expQ.size() == 0) begin
          totalChecks++;
          $display("[TB] FAIL unexpectedFrameStart: got a frame start, expected none at %0t", $time);
        end else begin
          expItem = expQ.pop_front();
          checkOutput("frameGap", offset, expItem.gap);
          checkOutput("colorAtStart", int'(oColor_SW), expItem.color);
          checkOutput("ackAtStart", int'(oMode_Ack), expItem.ack);
        end
        checkOutput("xAtStart", int'(oVGA_X), 0);
        checkOutput("yAtStart", int'(oVGA_Y), 0);
        lastColor = int'(oColor_SW);
        offset    = 0;
        haveFrame = 1'b1;
        clearStats();
      end else begin
        if (oMode_Ack) begin
          totalChecks++;
          $display("[TB] FAIL strayAck: got ack=1, expected 0 outside frame start at %0t", $time);
        end
        if (int'(oColor_SW) != lastColor) begin
          totalChecks++;
          $display("[TB] FAIL colorMidFrame: got %0d, expected %0d at %0t", oColor_SW, lastColor, $time);
          lastColor = int'(oColor_SW);
        end
      end
      accumulate(offset);
    end
  end

  // reset values must appear as soon as reset is asserted, without a clock edge
  always @(negedge rstN) begin
    #1;
    checkOutput("rstX", int'(oVGA_X), 0);
    checkOutput("rstY", int'(oVGA_Y), 0);
    checkOutput("rstColor", int'(oColor_SW), 1);
    checkOutput("rstHS", int'(oHS), 1);
    checkOutput("rstVS", int'(oVS), 1);
    checkOutput("rstBlank", int'(oBLANK_n), 0);
    checkOutput("rstAck", int'(oMode_Ack), 0);
    checkOutput("rstFrameStart", int'(oFrame_Start), 0);
  end

  task automatic releaseReset();
    expQ.push_back('{1, 1, 0});
    rstN = 1'b1;
  endtask

  // one full frame of stimulus; pushes the expected state of the following frame start
  task automatic applyStimulus(input bit autoOn, input int posA, input int valA,
                               input int posB, input int valB,
                               input int expColor, input int expAck);
    autoEn = autoOn;
    expQ.push_back('{FRAME_LEN, expColor, expAck});
    for (int p = 0; p < FRAME_LEN; p++) begin
      modeReq = (p == posA) || (p == posB);
      if (p == posA) modeVal = valA[0];
      else if (p == posB) modeVal = valB[0];
      @(posedge clk);
      #3;
    end
    modeReq = 1'b0;
  endtask

  // request left pending, then reset hits in the middle of a visible line
  task automatic resetWhilePending();
    autoEn = 1'b0;
    for (int p = 0; p < 31; p++) begin
      modeReq = (p == 10);
      if (p == 10) modeVal = 1'b1;
      @(posedge clk);
      #3;
    end
    modeReq = 1'b0;
    rstN    = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #3;
    end
    releaseReset();
  endtask

  initial begin
    clearStats();
    #1 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    releaseReset();

    // free-running frames after reset
    applyStimulus(0, -1, 0, -1, 0, 1, 0);
    applyStimulus(0, -1, 0, -1, 0, 1, 0);
    // single manual request mid-frame
    applyStimulus(0, 20, 0, -1, 0, 0, 1);
    // two requests in one frame, last wins
    applyStimulus(0, 20, 0, 50, 1, 1, 1);
    // request in the boundary cycle itself
    applyStimulus(0, 97, 0, -1, 0, 0, 1);
    // pending request overwritten in the boundary cycle
    applyStimulus(0, 30, 0, 97, 1, 1, 1);

    // automatic toggling every third frame
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, -1, 0, -1, 0, 0, 0);
    applyStimulus(1, -1, 0, -1, 0, 0, 0);
    applyStimulus(1, -1, 0, -1, 0, 0, 0);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);

    // pending request collides with a due auto toggle
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, 40, 1, -1, 0, 1, 1);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);
    applyStimulus(1, -1, 0, -1, 0, 0, 0);

    // disabling auto holds the frame count
    applyStimulus(1, -1, 0, -1, 0, 0, 0);
    applyStimulus(0, -1, 0, -1, 0, 0, 0);
    applyStimulus(0, -1, 0, -1, 0, 0, 0);
    applyStimulus(1, -1, 0, -1, 0, 0, 0);
    applyStimulus(1, -1, 0, -1, 0, 1, 0);

    // reset mid-line with a request pending
    applyStimulus(0, 20, 0, -1, 0, 0, 1);
    resetWhilePending();
    applyStimulus(0, -1, 0, -1, 0, 1, 0);
    applyStimulus(0, -1, 0, -1, 0, 1, 0);

    repeat (5) @(posedge clk);
    #3;
    checkOutput("framesOutstanding", expQ.size(), 0);
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
